// File: rtl/boot_rom_arbiter.sv
// Round-robin arbiter sharing a single-port, 1-cycle-latency boot ROM between NumReq requesters.
// Grants are combinational; responses are routed back through one registered {valid, idx, err} stage.
module boot_rom_arbiter #(
  parameter int          NumReq   = 2,
  parameter logic [31:0] RomBase  = 32'h0000_0000,
  parameter int          RomWords = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0][31:0]  addr_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  output logic                     rom_req_o,
  output logic [31:0]              rom_addr_o,
  input  logic [31:0]              rom_rdata_i
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  // Window bounds held in 33 bits so a window ending exactly at 2^32 does not wrap.
  localparam logic [32:0] RomLo = {1'b0, RomBase};
  localparam logic [32:0] RomHi = RomLo + (33'(RomWords) << 2);

  logic [IdxW-1:0] r_rr_ptr;
  logic            r_vld_p1;
  logic [IdxW-1:0] r_idx_p1;
  logic            r_err_p1;

  logic [NumReq-1:0] w_req;
  logic              w_gnt_any;
  logic [IdxW-1:0]   w_gnt_idx;
  logic [31:0]       w_gnt_addr;
  logic [32:0]       w_addr_al;
  logic              w_in_rng;
  logic [IdxW-1:0]   w_ptr_nxt;

  function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] k);
    if (k == IdxW'(NumReq - 1)) return '0;
    return k + 1'b1;
  endfunction

  // Requests are masked while reset is held so no grant leaks out of reset.
  assign w_req = req_i & {NumReq{rst_ni}};

  // Two descending passes: the second (indices at or above the pointer) overrides the
  // first (wrapped indices below the pointer), yielding the first request from rr_ptr upward.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (w_req[i] && (i < int'(r_rr_ptr))) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IdxW'(i);
      end
    end
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (w_req[i] && (i >= int'(r_rr_ptr))) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      gnt_o[i] = w_gnt_any && (w_gnt_idx == IdxW'(i));
    end
  end

  assign w_gnt_addr = w_gnt_any ? addr_i[w_gnt_idx] : 32'h0;
  assign w_addr_al  = {1'b0, w_gnt_addr[31:2], 2'b00};
  assign w_in_rng   = (w_addr_al >= RomLo) && (w_addr_al < RomHi);
  assign w_ptr_nxt  = next_ptr(w_gnt_idx);

  assign rom_req_o  = w_gnt_any && w_in_rng;
  assign rom_addr_o = w_gnt_addr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_any) begin
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  // ---- p0 -> p1: grant cycle captured as the pending response ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld_p1 <= 1'b0;
      r_idx_p1 <= '0;
      r_err_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_gnt_any;
      if (w_gnt_any) begin
        r_idx_p1 <= w_gnt_idx;
        r_err_p1 <= !w_in_rng;
      end
    end
  end

  // ---- p1: response routed to the requester granted one cycle earlier ----
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      rvalid_o[i] = r_vld_p1 && (r_idx_p1 == IdxW'(i));
    end
  end

  assign err_o   = r_vld_p1 && r_err_p1;
  assign rdata_o = (r_vld_p1 && !r_err_p1) ? rom_rdata_i : 32'h0;

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rvalid_o));
  a_rom_req_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni) rom_req_o |-> (|gnt_o));
  for (genvar k = 0; k < NumReq; k++) begin : g_asrt
    a_gnt_req: assert property (@(posedge clk_i) disable iff (!rst_ni) gnt_o[k] |-> req_i[k]);
    a_gnt_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni) gnt_o[k] |=> rvalid_o[k]);
  end
`endif

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Bench for boot_rom_arbiter: directed vector table, hand-written reset/window sequences,
// then randomized traffic compared against a queue-free behavioural arbitration model.
module tb_boot_rom_arbiter;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [N-1:0]     req;
  logic [N-1:0][31:0] addr;
  logic [N-1:0]     gnt, rvalid;
  logic [31:0]      rdata, rom_addr, rom_rdata;
  logic             err, rom_req;

  logic [N-1:0]     req2;
  logic [N-1:0][31:0] addr2;
  logic [N-1:0]     gnt2, rvalid2;
  logic [31:0]      rdata2, rom_addr2, rom_rdata2;
  logic             err2, rom_req2;

  logic [31:0] rom_mem [2];

  boot_rom_arbiter #(.NumReq(N), .RomBase(32'h0), .RomWords(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .rom_req_o(rom_req),
    .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata));

  boot_rom_arbiter #(.NumReq(N), .RomBase(32'h1000), .RomWords(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .addr_i(addr2), .gnt_o(gnt2),
    .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2), .rom_req_o(rom_req2),
    .rom_addr_o(rom_addr2), .rom_rdata_i(rom_rdata2));

  // ROM models: 1-cycle read latency, data changes only on a strobe.
  always @(posedge clk) if (rom_req) rom_rdata <= rom_mem[rom_addr[2]];
  always @(posedge clk) if (rom_req2) rom_rdata2 <= 32'hA5A5_0000 ^ rom_addr2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  gnt;
    logic        rr;
    logic [31:0] ra;
    logic [1:0]  rv;
    logic        er;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [11];

  // Behavioural reference for the random phase.
  int          m_ptr;
  bit          m_pv;
  int          m_pidx;
  bit          m_perr;
  logic [31:0] m_pdata;

  initial begin
    rom_mem[0] = 32'h1234_5678;
    rom_mem[1] = 32'hDEAD_BEEF;
    rom_rdata  = 32'h0;
    rom_rdata2 = 32'h0;

    //            req    a0     a1     gnt    rr    ra     rv     er    rd
    tbl[0]  = '{2'b01, 32'h4, 32'h0, 2'b01, 1'b1, 32'h4, 2'b00, 1'b0, 32'h0};
    tbl[1]  = '{2'b10, 32'h0, 32'h8, 2'b10, 1'b0, 32'h8, 2'b01, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b10, 1'b1, 32'h0};
    tbl[3]  = '{2'b11, 32'h0, 32'h4, 2'b01, 1'b1, 32'h0, 2'b00, 1'b0, 32'h0};
    tbl[4]  = '{2'b11, 32'h0, 32'h4, 2'b10, 1'b1, 32'h4, 2'b01, 1'b0, 32'h1234_5678};
    tbl[5]  = '{2'b11, 32'h0, 32'h4, 2'b01, 1'b1, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF};
    tbl[6]  = '{2'b11, 32'h0, 32'h4, 2'b10, 1'b1, 32'h4, 2'b01, 1'b0, 32'h1234_5678};
    tbl[7]  = '{2'b01, 32'h0, 32'h4, 2'b01, 1'b1, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF};
    tbl[8]  = '{2'b01, 32'h4, 32'h0, 2'b01, 1'b1, 32'h4, 2'b01, 1'b0, 32'h1234_5678};
    tbl[9]  = '{2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b01, 1'b0, 32'hDEAD_BEEF};
    tbl[10] = '{2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0};

    rst_n = 1'b0;
    req   = 2'b11;
    addr  = '{32'h4, 32'h0};
    req2  = 2'b00;
    addr2 = '0;

    // Held in reset with both requesters asking.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rom_req", 32'(rom_req), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("first_gnt_req0", 32'(gnt), 32'h1);

    foreach (tbl[i]) begin
      req  = tbl[i].req;
      addr = '{tbl[i].a1, tbl[i].a0};
      #3;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_rom_req", i), 32'(rom_req), 32'(tbl[i].rr));
      chk($sformatf("v%0d_rom_addr", i), rom_addr, tbl[i].ra);
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].er));
      chk($sformatf("v%0d_rdata", i), rdata, tbl[i].rd);
      @(posedge clk);
      #1;
    end

    // Reset asserted the cycle after a grant: the pending response is dropped.
    req  = 2'b01;
    addr = '{32'h0, 32'h4};
    #3;
    chk("mid_gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = 2'b00;
    #1;
    chk("mid_rvalid_dropped", 32'(rvalid), 32'h0);
    chk("mid_rdata_dropped", rdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 2'b11;
    addr  = '{32'h4, 32'h0};
    #3;
    chk("post_rst_ptr0", 32'(gnt), 32'h1);
    chk("post_rst_no_stale", 32'(rvalid), 32'h0);
    @(posedge clk);
    #1;
    req = 2'b10;
    #3;
    chk("post_rst_gnt1", 32'(gnt), 32'h2);
    chk("post_rst_rvalid0", 32'(rvalid), 32'h1);
    chk("post_rst_rdata0", rdata, 32'h1234_5678);
    @(posedge clk);
    #1;
    req = 2'b00;
    #3;
    chk("post_rst_rvalid1", 32'(rvalid), 32'h2);
    chk("post_rst_rdata1", rdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;

    // Window at 0x1000: below-base, last word and one-past-end.
    req2  = 2'b01;
    addr2 = '{32'h0, 32'h0000_0FFC};
    #3;
    chk("w2_below_gnt", 32'(gnt2), 32'h1);
    chk("w2_below_rom_req", 32'(rom_req2), 32'h0);
    @(posedge clk);
    #1;
    addr2 = '{32'h0, 32'h0000_1004};
    #3;
    chk("w2_last_rom_req", 32'(rom_req2), 32'h1);
    chk("w2_below_rvalid", 32'(rvalid2), 32'h1);
    chk("w2_below_err", 32'(err2), 32'h1);
    chk("w2_below_rdata", rdata2, 32'h0);
    @(posedge clk);
    #1;
    addr2 = '{32'h0, 32'h0000_1008};
    #3;
    chk("w2_end_rom_req", 32'(rom_req2), 32'h0);
    chk("w2_last_err", 32'(err2), 32'h0);
    chk("w2_last_rdata", rdata2, 32'hA5A5_1004);
    @(posedge clk);
    #1;
    req2 = 2'b00;
    #3;
    chk("w2_end_rvalid", 32'(rvalid2), 32'h1);
    chk("w2_end_err", 32'(err2), 32'h1);
    chk("w2_end_rdata", rdata2, 32'h0);
    @(posedge clk);
    #1;

    // Random traffic against the reference model, starting from a fresh reset.
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_pv   = 1'b0;
    m_pidx = 0;
    m_perr = 1'b0;
    m_pdata = 32'h0;
    for (int c = 0; c < 400; c++) begin
      int          gk;
      longint      a;
      bit          in_rng;
      logic [31:0] e_gnt, e_rv, e_addr;
      req = N'($urandom);
      for (int r = 0; r < N; r++) begin
        case ($urandom_range(0, 5))
          0: addr[r] = 32'h0;
          1: addr[r] = 32'h4 | 32'($urandom_range(0, 3));
          2: addr[r] = 32'h8;
          3: addr[r] = 32'hC;
          4: addr[r] = 32'hFFFF_FFFC;
          default: addr[r] = $urandom;
        endcase
      end
      #3;
      gk = -1;
      for (int j = 0; j < N; j++) begin
        int k;
        k = (m_ptr + j) % N;
        if (req[k] && gk < 0) gk = k;
      end
      e_gnt  = (gk >= 0) ? (32'h1 << gk) : 32'h0;
      a      = (gk >= 0) ? longint'(addr[gk] & 32'hFFFF_FFFC) : 0;
      in_rng = (gk >= 0) && (a >= 0) && (a < 8);
      e_addr = (gk >= 0) ? addr[gk] : 32'h0;
      e_rv   = m_pv ? (32'h1 << m_pidx) : 32'h0;
      chk("rnd_gnt", 32'(gnt), e_gnt);
      chk("rnd_rom_req", 32'(rom_req), 32'(in_rng));
      chk("rnd_rom_addr", rom_addr, e_addr);
      chk("rnd_rvalid", 32'(rvalid), e_rv);
      chk("rnd_err", 32'(err), 32'(m_pv && m_perr));
      chk("rnd_rdata", rdata, (m_pv && !m_perr) ? m_pdata : 32'h0);
      m_pv = (gk >= 0);
      if (gk >= 0) begin
        m_pidx  = gk;
        m_perr  = !in_rng;
        m_pdata = in_rng ? rom_mem[int'(a / 4)] : 32'h0;
        m_ptr   = (gk + 1) % N;
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
